// File: rtl/mem_pkg.sv
// Shared types and limits for the memory responder and its RAM array.
package mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_ram_array.sv
// Single-port synchronous word RAM with registered read data.
module mem_ram_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; program images and data must survive a CPU reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder: latches a request, waits WAIT_CYCLES, accesses RAM, holds Done.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Busy,
  output logic              Error
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              error_q, error_d;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;
  logic              strobe_held;

  assign strobe_held = (op_q == OP_WRITE) ? Write : Read;

  // The RAM read takes one edge, so ACCESS spends one extra cycle after issuing.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    din_d    = din_q;
    op_d     = op_q;
    dout_d   = dout_q;
    error_d  = 1'b0;
    ram_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Read && Write) begin
          error_d = 1'b1;
        end else if (Read || Write) begin
          addr_d   = Address;
          din_d    = DataIn;
          op_d     = Write ? OP_WRITE : OP_READ;
          cnt_d    = CNT_LOAD;
          issued_d = 1'b0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!strobe_held) begin
          state_d = ST_IDLE;
        end else if (issued_q) begin
          if (op_q == OP_READ) dout_d = ram_dout;
          state_d = ST_DONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ram_en   = 1'b1;
          issued_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!strobe_held) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      dout_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      dout_q   <= dout_d;
      error_q  <= error_d;
    end
  end

  // Request latches are only meaningful once ACCESS is entered, so they carry no reset.
  always_ff @(posedge Clock) begin
    addr_q <= addr_d;
    din_q  <= din_d;
    op_q   <= op_d;
  end

  // Gating with Reset discards a write whose commit edge coincides with reset.
  mem_ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk (Clock),
    .en  (ram_en && Reset),
    .we  (ram_en && Reset && (op_q == OP_WRITE)),
    .addr(addr_q),
    .din (din_q),
    .dout(ram_dout)
  );

  assign DataOut = dout_q;
  assign Done    = (state_q == ST_DONE);
  assign Busy    = (state_q == ST_ACCESS) || (state_q == ST_DONE);
  assign Error   = error_q;

endmodule
